// File: rtl/sseg_bcd_scan.sv
// Four-digit seven-segment driver: hex or double-dabble decimal, multiplexed scan.
// Build option SSEG_LZB_EN: blank leading zeros in decimal mode.
module sseg_bcd_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MODE,
  input  logic [15:0] DATA_IN,
  output logic        BUSY,
  output logic [7:0]  CATHODES,
  output logic [3:0]  ANODES
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Digit symbols: 0..15 are hex values, 16 is dash, 17 is blank.
  localparam logic [4:0] SYM_DASH  = 5'd16;
  localparam logic [4:0] SYM_BLANK = 5'd17;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t            state;
  logic [3:0]        iter;
  logic [31:0]       dd;
  logic              mode_q;
  logic              ovf_q;
  logic [3:0][4:0]   digits;
  logic [CW-1:0]     scan_cnt;
  logic [1:0]        dig_idx;

  logic [15:0]       bcd_adj;
  logic [31:0]       dd_adj;
  logic [3:0][4:0]   hex_sym;
  logic [3:0][4:0]   dec_sym;

  function automatic logic [7:0] seg7(input logic [4:0] s);
    case (s)
      5'd0:  seg7 = 8'hC0;
      5'd1:  seg7 = 8'hF9;
      5'd2:  seg7 = 8'hA4;
      5'd3:  seg7 = 8'hB0;
      5'd4:  seg7 = 8'h99;
      5'd5:  seg7 = 8'h92;
      5'd6:  seg7 = 8'h82;
      5'd7:  seg7 = 8'hF8;
      5'd8:  seg7 = 8'h80;
      5'd9:  seg7 = 8'h90;
      5'd10: seg7 = 8'h88;
      5'd11: seg7 = 8'h83;
      5'd12: seg7 = 8'hC6;
      5'd13: seg7 = 8'hA1;
      5'd14: seg7 = 8'h86;
      5'd15: seg7 = 8'h8E;
      5'd16: seg7 = 8'hBF;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble ahead of the shift.
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign bcd_adj[g*4 +: 4] = (dd[16 + g*4 +: 4] >= 4'd5) ? dd[16 + g*4 +: 4] + 4'd3
                                                          : dd[16 + g*4 +: 4];
    assign hex_sym[g] = {1'b0, dd[g*4 +: 4]};
  end
  assign dd_adj = {bcd_adj, dd[15:0]};

  always_comb begin
    for (int i = 0; i < 4; i++) dec_sym[i] = {1'b0, dd[16 + i*4 +: 4]};
    if (ovf_q) dec_sym = {4{SYM_DASH}};
`ifdef SSEG_LZB_EN
    if (!ovf_q) begin
      if (dd[31:28] == 4'd0) dec_sym[3] = SYM_BLANK;
      if (dd[31:24] == 8'd0) dec_sym[2] = SYM_BLANK;
      if (dd[31:20] == 12'd0) dec_sym[1] = SYM_BLANK;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      iter   <= 4'd0;
      dd     <= 32'd0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
      digits <= '0;
    end else begin
      case (state)
        IDLE: begin
          dd     <= {16'd0, DATA_IN};
          mode_q <= MODE;
          ovf_q  <= MODE && (DATA_IN > 16'd9999);
          iter   <= 4'd0;
          state  <= MODE ? SHIFT : UPDATE;
          BUSY   <= 1'b1;
        end
        SHIFT: begin
          dd   <= dd_adj << 1;
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= UPDATE;
        end
        UPDATE: begin
          digits <= mode_q ? dec_sym : hex_sym;
          state  <= IDLE;
          BUSY   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Anode and cathode load together on the wrap edge so no digit shows stale segments.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      ANODES   <= 4'hF;
      CATHODES <= 8'hFF;
    end else if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
      scan_cnt <= '0;
      ANODES   <= ~(4'b0001 << dig_idx);
      CATHODES <= seg7(digits[dig_idx]);
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

endmodule
